// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM feeder and the PWM counter/compare stage.
// Both sides take their value width from here so they stay in agreement.
package pwm_pkg;

   localparam int PWM_W     = 28;
   localparam int PWM_DIV_W = 16;
   localparam logic [PWM_W-1:0] PWM_DEF_PERIOD = 28'd50_000_000;

   localparam logic [1:0] MODE_DIRECT  = 2'd0;
   localparam logic [1:0] MODE_RAMP    = 2'd1;
   localparam logic [1:0] MODE_BREATHE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RAMP = 2'd1,
      ST_UP   = 2'd2,
      ST_DN   = 2'd3
   } pwm_state_e;

endpackage

// File: rtl/pwm_tick_div.sv
// Divides qualified PWM cycle-end pulses: tick fires on every (div+1)-th pulse.
// clr restarts the count; tick is still reported from the pre-clear count.
module pwm_tick_div #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             cyc_en,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = cyc_en && (cnt_q == div);
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (cyc_en) begin
         cnt_d = (cnt_q == div) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Feeds period/decode values to the PWM stage, updating them only on cycle
// boundaries; supports direct set, ramp-to-target and triangle breathing.
module pwm_duty_ramp
   import pwm_pkg::*;
#(
   parameter int            W          = PWM_W,
   parameter int            DIV_W      = PWM_DIV_W,
   parameter logic [W-1:0]  DEF_PERIOD = W'(PWM_DEF_PERIOD)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             enable,
   input  logic             load,
   input  logic [1:0]       mode_in,
   input  logic [W-1:0]     period_in,
   input  logic [W-1:0]     target_in,
   input  logic [W-1:0]     step_in,
   input  logic [DIV_W-1:0] div_in,
   input  logic             cyc_end,
   output logic [W-1:0]     period_out,
   output logic [W-1:0]     decode_out,
   output logic             busy,
   output logic             at_target,
   output pwm_state_e       state_dbg
);

   logic [W-1:0]     period_s_q, period_s_d, target_s_q, target_s_d;
   logic [W-1:0]     step_s_q, step_s_d;
   logic [DIV_W-1:0] div_s_q, div_s_d;
   logic [1:0]       mode_s_q, mode_s_d;

   pwm_state_e   state_q, state_d;
   logic [W-1:0] period_q, period_d, decode_q, decode_d;
   logic         at_target_q, at_target_d;

   logic         tick;
   logic [W-1:0] per_eff, tgt_eff, step_eff, dec_c, dec_n;
   logic [W-1:0] up_ramp, dn_ramp, up_br, dn_br;
   logic [W:0]   sum_x;

   pwm_tick_div #(.DIV_W(DIV_W)) u_tick_div (
      .clk    (CLK),
      .rst    (RST),
      .clr    (load | ~enable),
      .cyc_en (cyc_end & enable),
      .div    (div_s_q),
      .tick   (tick)
   );

   always_comb begin
      period_s_d = period_s_q;
      target_s_d = target_s_q;
      step_s_d   = step_s_q;
      div_s_d    = div_s_q;
      mode_s_d   = mode_s_q;
      if (load) begin
         period_s_d = period_in;
         target_s_d = target_in;
         step_s_d   = step_in;
         div_s_d    = div_in;
         mode_s_d   = mode_in;
      end
   end

   // Effective setpoints from the shadow; dec_c is decode already clamped to the new period.
   always_comb begin
      per_eff  = (period_s_q == '0) ? W'(1) : period_s_q;
      tgt_eff  = (target_s_q > per_eff) ? per_eff : target_s_q;
      step_eff = (step_s_q == '0) ? W'(1) : step_s_q;
      dec_c    = (decode_q > per_eff) ? per_eff : decode_q;
      sum_x    = {1'b0, dec_c} + {1'b0, step_eff};
      up_ramp  = (sum_x > {1'b0, tgt_eff}) ? tgt_eff : sum_x[W-1:0];
      dn_ramp  = ({1'b0, dec_c} > ({1'b0, tgt_eff} + {1'b0, step_eff})) ?
                 dec_c - step_eff : tgt_eff;
      up_br    = (sum_x > {1'b0, per_eff}) ? per_eff : sum_x[W-1:0];
      dn_br    = (dec_c > step_eff) ? dec_c - step_eff : '0;
   end

   always_comb begin
      state_d     = state_q;
      period_d    = period_q;
      decode_d    = decode_q;
      at_target_d = at_target_q;
      dec_n       = dec_c;
      if (!enable) begin
         state_d = ST_IDLE;
      end else if (cyc_end) begin
         period_d = per_eff;
         // Dispatch on the shadow mode each cycle so a mode change continues from dec_c.
         case (mode_s_q)
            MODE_RAMP: begin
               if (tick) dec_n = (dec_c < tgt_eff) ? up_ramp : dn_ramp;
               state_d = (dec_n == tgt_eff) ? ST_IDLE : ST_RAMP;
            end
            MODE_BREATHE: begin
               if (state_q == ST_DN) begin
                  if (tick) dec_n = dn_br;
                  state_d = (dec_n == '0) ? ST_UP : ST_DN;
               end else begin
                  if (tick) dec_n = up_br;
                  state_d = (dec_n == per_eff) ? ST_DN : ST_UP;
               end
            end
            default: begin
               dec_n   = tgt_eff;
               state_d = ST_IDLE;
            end
         endcase
         decode_d    = dec_n;
         at_target_d = (dec_n == tgt_eff) && (state_d != ST_UP) && (state_d != ST_DN);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         period_s_q  <= DEF_PERIOD;
         target_s_q  <= '0;
         step_s_q    <= W'(1);
         div_s_q     <= '0;
         mode_s_q    <= MODE_DIRECT;
         state_q     <= ST_IDLE;
         period_q    <= DEF_PERIOD;
         decode_q    <= '0;
         at_target_q <= 1'b1;
      end else begin
         period_s_q  <= period_s_d;
         target_s_q  <= target_s_d;
         step_s_q    <= step_s_d;
         div_s_q     <= div_s_d;
         mode_s_q    <= mode_s_d;
         state_q     <= state_d;
         period_q    <= period_d;
         decode_q    <= decode_d;
         at_target_q <= at_target_d;
      end
   end

   assign period_out = period_q;
   assign decode_out = decode_q;
   assign busy       = (state_q != ST_IDLE);
   assign at_target  = at_target_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp: hand-computed expectations checked with
// immediate assertions at the falling edge after each stimulus step.
module tb_pwm_duty_ramp;
   import pwm_pkg::*;

   localparam int W     = 28;
   localparam int DIV_W = 16;
   localparam int DEF_P = 50_000_000;

   // Clock/reset: outputs sampled on the falling edge, inputs driven there too.
   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic             enable = 1'b1;
   logic             load = 1'b0;
   logic [1:0]       mode_in = 2'd0;
   logic [W-1:0]     period_in = '0;
   logic [W-1:0]     target_in = '0;
   logic [W-1:0]     step_in = '0;
   logic [DIV_W-1:0] div_in = '0;
   logic             cyc_end = 1'b0;
   logic [W-1:0]     period_out, decode_out;
   logic             busy, at_target;
   pwm_state_e       state_dbg;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   pwm_duty_ramp dut (
      .CLK        (CLK),
      .RST        (RST),
      .enable     (enable),
      .load       (load),
      .mode_in    (mode_in),
      .period_in  (period_in),
      .target_in  (target_in),
      .step_in    (step_in),
      .div_in     (div_in),
      .cyc_end    (cyc_end),
      .period_out (period_out),
      .decode_out (decode_out),
      .busy       (busy),
      .at_target  (at_target),
      .state_dbg  (state_dbg)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int per, input int dec,
                          input logic b, input logic at);
      chk({tag, ".period"}, 32'(period_out), 32'(per));
      chk({tag, ".decode"}, 32'(decode_out), 32'(dec));
      chk({tag, ".busy"}, 32'(busy), 32'(b));
      chk({tag, ".at_target"}, 32'(at_target), 32'(at));
   endtask

   task automatic chk_dec(input string tag, input int dec, input logic b);
      chk({tag, ".decode"}, 32'(decode_out), 32'(dec));
      chk({tag, ".busy"}, 32'(busy), 32'(b));
   endtask

   // Driver tasks
   task automatic set_inputs(input logic [1:0] m, input int p, input int t,
                             input int s, input int d);
      mode_in   = m;
      period_in = W'(p);
      target_in = W'(t);
      step_in   = W'(s);
      div_in    = DIV_W'(d);
   endtask

   task automatic do_load(input logic [1:0] m, input int p, input int t,
                          input int s, input int d);
      @(negedge CLK);
      set_inputs(m, p, t, s, d);
      load = 1'b1;
      @(negedge CLK);
      load = 1'b0;
   endtask

   task automatic load_with_cyc(input logic [1:0] m, input int p, input int t,
                                input int s, input int d);
      @(negedge CLK);
      set_inputs(m, p, t, s, d);
      load    = 1'b1;
      cyc_end = 1'b1;
      @(negedge CLK);
      load    = 1'b0;
      cyc_end = 1'b0;
   endtask

   task automatic cyc_pulse();
      @(negedge CLK);
      cyc_end = 1'b1;
      @(negedge CLK);
      cyc_end = 1'b0;
   endtask

   initial begin
      // Reset held
      #12;
      chk_out("reset", DEF_P, 0, 1'b0, 1'b1);
      @(negedge CLK);
      RST = 1'b0;

      // Idle cycle ends with no load
      repeat (3) cyc_pulse();
      chk_out("idle_cyc", DEF_P, 0, 1'b0, 1'b1);

      // DIRECT: nothing moves on load, everything moves on cyc_end
      do_load(MODE_DIRECT, 1000, 250, 1, 0);
      chk_out("direct_load", DEF_P, 0, 1'b0, 1'b1);
      cyc_pulse();
      chk_out("direct_apply", 1000, 250, 1'b0, 1'b1);

      do_load(MODE_DIRECT, 1000, 0, 1, 0);
      cyc_pulse();
      chk_out("direct_zero", 1000, 0, 1'b0, 1'b1);

      // RAMP up by 30 to 100
      do_load(MODE_RAMP, 1000, 100, 30, 0);
      cyc_pulse(); chk_out("ramp_up1", 1000, 30, 1'b1, 1'b0);
      cyc_pulse(); chk_dec("ramp_up2", 60, 1'b1);
      cyc_pulse(); chk_dec("ramp_up3", 90, 1'b1);
      cyc_pulse(); chk_out("ramp_up4", 1000, 100, 1'b0, 1'b1);

      // RAMP down by 30 to 0 without underflow
      do_load(MODE_RAMP, 1000, 0, 30, 0);
      cyc_pulse(); chk_dec("ramp_dn1", 70, 1'b1);
      cyc_pulse(); chk_dec("ramp_dn2", 40, 1'b1);
      cyc_pulse(); chk_dec("ramp_dn3", 10, 1'b1);
      cyc_pulse(); chk_out("ramp_dn4", 1000, 0, 1'b0, 1'b1);

      // BREATHE period 10 step 4, tick every 2nd cycle end
      do_load(MODE_BREATHE, 10, 0, 4, 1);
      cyc_pulse(); chk_out("br_c1", 10, 0, 1'b1, 1'b0);
      cyc_pulse(); chk_dec("br_c2", 4, 1'b1);
      cyc_pulse(); chk_dec("br_c3", 4, 1'b1);
      cyc_pulse(); chk_dec("br_c4", 8, 1'b1);
      cyc_pulse(); cyc_pulse(); chk_dec("br_c6", 10, 1'b1);
      cyc_pulse(); cyc_pulse(); chk_dec("br_c8", 6, 1'b1);
      cyc_pulse(); cyc_pulse(); chk_dec("br_c10", 2, 1'b1);
      cyc_pulse(); cyc_pulse(); chk_dec("br_c12", 0, 1'b1);
      cyc_pulse(); cyc_pulse(); chk_out("br_c14", 10, 4, 1'b1, 1'b0);

      // enable low mid-breathe: frozen outputs, sequence dropped to idle
      @(negedge CLK);
      enable = 1'b0;
      cyc_pulse(); cyc_pulse();
      chk_out("disabled", 10, 4, 1'b0, 1'b0);
      @(negedge CLK);
      enable = 1'b1;
      cyc_pulse(); chk_dec("reen_c1", 4, 1'b1);
      cyc_pulse(); chk_dec("reen_c2", 8, 1'b1);

      // load coinciding with cyc_end applies the old shadow first
      do_load(MODE_DIRECT, 1000, 300, 1, 0);
      load_with_cyc(MODE_DIRECT, 1000, 2000, 1, 0);
      chk_out("same_edge_old", 1000, 300, 1'b0, 1'b1);
      cyc_pulse();
      chk_out("same_edge_new_clamped", 1000, 1000, 1'b0, 1'b1);

      // Period shrink clamps decode in the same cycle
      do_load(MODE_DIRECT, 1000, 600, 1, 0);
      cyc_pulse();
      chk_out("pre_shrink", 1000, 600, 1'b0, 1'b1);
      do_load(MODE_RAMP, 200, 600, 1, 5);
      cyc_pulse();
      chk_out("shrink", 200, 200, 1'b0, 1'b1);

      // Reset in the middle of a ramp
      do_load(MODE_RAMP, 1000, 900, 10, 0);
      cyc_pulse();
      chk_out("mid_ramp", 1000, 210, 1'b1, 1'b0);
      @(negedge CLK);
      RST = 1'b1;
      #1;
      chk_out("mid_ramp_rst", DEF_P, 0, 1'b0, 1'b1);
      @(negedge CLK);
      RST = 1'b0;
      cyc_pulse();
      chk_out("after_rst", DEF_P, 0, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
